seg_display_bcd: RTL

- Parametrised multi-channel seven-segment display controller for the pipelined computer's output ports.
- Round-robin converts NUM_CH binary channels into DIGITS decimal digits each, using a sequential double-dabble engine (one bit per cycle).
- Drives active-low segment outputs with optional leading-zero blanking and overflow indication.
- Replaces the fixed 3-port, 2-digit display path and its combinational divide.

---
 rtl/seg_display_bcd_pkg.sv | 19 +
 rtl/seg_display_bcd_seg_decode.sv | 14 +
 rtl/seg_display_bcd.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg_display_bcd_pkg.sv
// Shared constants and FSM encoding for the multi-channel BCD seven-segment display.
package seg_display_bcd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low gfedcba patterns for decimal digits 0..9
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STORE = 2'd2
  } state_t;

endpackage

// File: rtl/seg_display_bcd_seg_decode.sv
// Single BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg_decode
  import seg_display_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/seg_display_bcd.sv
// Round-robin multi-channel seven-segment controller: one double-dabble engine
// shared by all channels, one bit per cycle, registered active-low outputs.
module seg_display_bcd
  import seg_display_bcd_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH*DIGITS*7-1:0] hex,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam int BCD_W = DIGITS * 4;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t             state_q;
  logic [CH_W-1:0]    ch_idx;
  logic [DATA_W-1:0]  shreg;
  logic [BCD_W-1:0]   bcd;
  logic               ovf;
  logic [CNT_W-1:0]   bit_cnt;

  logic [DATA_W-1:0]  ch_sel;
  logic [BCD_W-1:0]   bcd_adj;
  logic [6:0]         dec_seg  [DIGITS];
  logic [6:0]         disp_seg [DIGITS];
  logic               nz_above;

  always_comb begin
    ch_sel = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (CH_W'(k) == ch_idx) ch_sel = ch_data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned d = 0; d < DIGITS; d++)
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg_decode u_dec (
      .digit (bcd[g*4 +: 4]),
      .seg   (dec_seg[g])
    );
  end

  // Walk from the top digit down so "any nonzero at or above" is known per digit
  always_comb begin
    nz_above = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) disp_seg[d] = SEG_BLANK;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      nz_above = nz_above | (bcd[(i-1)*4 +: 4] != 4'd0);
      if (ovf)
        disp_seg[i-1] = SEG_DASH;
      else if ((BLANK_LZ != 0) && (i > 1) && !nz_above)
        disp_seg[i-1] = SEG_BLANK;
      else
        disp_seg[i-1] = dec_seg[i-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ch_idx     <= '0;
      shreg      <= '0;
      bcd        <= '0;
      ovf        <= 1'b0;
      bit_cnt    <= '0;
      hex        <= '1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            shreg   <= ch_sel;
            bcd     <= '0;
            ovf     <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // A carry out of the top adjusted nibble means value >= 10^DIGITS
          {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
          ovf          <= ovf | bcd_adj[BCD_W-1];
          bit_cnt      <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state_q <= STORE;
        end
        STORE: begin
          for (int unsigned k = 0; k < NUM_CH; k++)
            if (CH_W'(k) == ch_idx)
              for (int unsigned d = 0; d < DIGITS; d++)
                hex[(k*DIGITS + d)*7 +: 7] <= disp_seg[d];
          ch_idx     <= (ch_idx == LAST_CH) ? '0 : ch_idx + CH_W'(1);
          frame_done <= (ch_idx == LAST_CH);
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
